// File: rtl/risc16_pkg.sv
// ---------------------------------------------------------------------------
// risc16_pkg
// Types and defaults shared by the risc16 data-RAM arbiter and the CPU core.
//   lock_state_e : host bus-lock state (UNLOCKED, LOCKED)
//   owner_e      : which port a pending read belongs to (OWN_CPU, OWN_HOST)
//   RISC16_ADDR_W / RISC16_DATA_W : RAM geometry defaults (256 x 16)
//   STARVE_CNT_W : width of the host starvation counter
// ---------------------------------------------------------------------------
package risc16_pkg;

    localparam int RISC16_ADDR_W = 8;
    localparam int RISC16_DATA_W = 16;
    localparam int STARVE_CNT_W  = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

endpackage

// File: rtl/risc16_starve_cnt.sv
// ---------------------------------------------------------------------------
// risc16_starve_cnt
// Saturating counter of consecutive cycles in which the host asked for the
// RAM and was refused. Saturates at STARVE_MAX; at_max_o tells the arbiter
// that the host must win its next request.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   inc_i    in   host requested but was not granted this cycle
//   clr_i    in   host was granted, or is not requesting
//   at_max_o out  counter equals STARVE_MAX
// ---------------------------------------------------------------------------
module risc16_starve_cnt
    import risc16_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/risc16_mem_arb.sv
// ---------------------------------------------------------------------------
// risc16_mem_arb
// Shares the single-port risc16 data RAM (synchronous read, 1-cycle latency)
// between the CPU load/store port and a host load/debug port. The CPU has
// fixed priority; a starvation counter forces a host grant after STARVE_MAX
// refused cycles, and host_lock keeps the RAM with the host across a burst.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   cpu_req/we/addr/wdata  in        CPU access request (held until cpu_gnt)
//   cpu_gnt                out       CPU access accepted this cycle
//   cpu_rvalid/rdata       out       CPU read return, one cycle after gnt
//   host_req/we/addr/wdata in        host access request (held until host_gnt)
//   host_lock              in        host wants to keep the bus after this access
//   host_gnt/rvalid/rdata  out       host grant and read return
//   ram_en/we/addr/wdata   out       RAM macro drive
//   ram_rdata              in        RAM read data (valid 1 cycle after read)
// ---------------------------------------------------------------------------
module risc16_mem_arb
    import risc16_pkg::*;
#(
    parameter int ADDR_W     = RISC16_ADDR_W,
    parameter int DATA_W     = RISC16_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    lock_state_e state_q, state_d;
    logic        rd_pend_q, rd_pend_d;
    owner_e      rd_owner_q, rd_owner_d;

    logic cpu_win;
    logic host_win;
    logic starve_at_max;

    // Host starvation counter: counts refused host cycles, clears otherwise.
    risc16_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_i    (host_req & ~host_win),
        .clr_i    (host_win | ~host_req),
        .at_max_o (starve_at_max)
    );

    // Grant decision. Everything is suppressed while reset is asserted so the
    // RAM is never touched during reset.
    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (rst_n) begin
            if (state_q == LOCKED) begin
                host_win = host_req;
            end else if (starve_at_max && host_req) begin
                host_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (host_req) begin
                host_win = 1'b1;
            end
        end
    end

    assign cpu_gnt  = cpu_win;
    assign host_gnt = host_win;

    // RAM drive: winner's fields, all-zero when idle.
    always_comb begin
        ram_en    = cpu_win | host_win;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_win) begin
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (host_win) begin
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end
    end

    // Lock FSM. A lock only takes hold on an actual host grant; it is released
    // as soon as the host drops either lock or request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            UNLOCKED: if (host_win && host_lock)    state_d = LOCKED;
            LOCKED:   if (!host_lock || !host_req)  state_d = UNLOCKED;
            default:                                state_d = UNLOCKED;
        endcase
    end

    // Read-return tag: remembers that the RAM output next cycle belongs to
    // a particular port.
    always_comb begin
        rd_pend_d  = ram_en & ~ram_we;
        rd_owner_d = host_win ? OWN_HOST : OWN_CPU;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= UNLOCKED;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CPU;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Gating with rst_n drops a return that was in flight when reset arrived.
    assign cpu_rvalid  = rst_n & rd_pend_q & (rd_owner_q == OWN_CPU);
    assign host_rvalid = rst_n & rd_pend_q & (rd_owner_q == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? ram_rdata : '0;
    assign host_rdata  = host_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_risc16_mem_arb.sv
module tb_risc16_mem_arb;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    risc16_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // RAM macro stand-in: 256 x 16, write at the edge, registered read.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram[ram_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [256];
    int            m_starve = 0, n_starve = 0;
    bit            m_locked = 0, n_locked = 0;
    bit            m_pend = 0, n_pend = 0;
    bit            m_own_h = 0, n_own_h = 0;
    logic [DW-1:0] m_pdata = '0, n_pdata = '0;
    logic          e_cgnt, e_hgnt, e_en, e_we, e_crv, e_hrv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_crd, e_hrd;

    task automatic predict();
        e_cgnt = 0; e_hgnt = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        e_crv = 0; e_hrv = 0; e_crd = '0; e_hrd = '0;
        if (!rst_n) begin
            n_starve = 0; n_locked = 0; n_pend = 0; n_own_h = 0; n_pdata = '0;
            return;
        end
        e_crv = m_pend && !m_own_h;
        e_hrv = m_pend && m_own_h;
        e_crd = e_crv ? m_pdata : '0;
        e_hrd = e_hrv ? m_pdata : '0;
        if (m_locked)                       e_hgnt = host_req;
        else if (m_starve >= SMAX && host_req) e_hgnt = 1;
        else if (cpu_req)                   e_cgnt = 1;
        else if (host_req)                  e_hgnt = 1;
        e_en = e_cgnt | e_hgnt;
        if (e_cgnt) begin e_we = cpu_we;  e_addr = cpu_addr;  e_wdata = cpu_wdata;  end
        if (e_hgnt) begin e_we = host_we; e_addr = host_addr; e_wdata = host_wdata; end
        n_pend  = e_en && !e_we;
        n_own_h = e_hgnt;
        n_pdata = n_pend ? ref_mem[e_addr] : '0;
        if (e_en && e_we) ref_mem[e_addr] = e_wdata;
        n_starve = (host_req && !e_hgnt) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        n_locked = m_locked ? (host_req && host_lock) : (e_hgnt && host_lock);
    endtask

    task automatic drive(input logic rn, input logic cr, input logic cw,
                         input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input logic hr, input logic hw, input logic [AW-1:0] ha,
                         input logic [DW-1:0] hd, input logic hl);
        @(negedge clk);
        rst_n = rn;
        cpu_req = cr;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd; host_lock = hl;
        #1;
        predict();
        if (cpu_gnt)  $display("[%0t] txn cpu  %s addr=%02h wdata=%04h", $time, cpu_we ? "wr" : "rd", cpu_addr, cpu_wdata);
        if (host_gnt) $display("[%0t] txn host %s addr=%02h wdata=%04h lock=%0b", $time, host_we ? "wr" : "rd", host_addr, host_wdata, host_lock);
    endtask

    task automatic tick();
        @(posedge clk);
        m_starve = n_starve; m_locked = n_locked; m_pend = n_pend;
        m_own_h = n_own_h; m_pdata = n_pdata;
    endtask

    task automatic idle();
        drive(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    function automatic logic [61:0] got_vec();
        return {cpu_gnt, host_gnt, ram_en, ram_we, ram_addr, ram_wdata,
                cpu_rvalid, host_rvalid, cpu_rdata, host_rdata};
    endfunction

    function automatic logic [61:0] exp_vec();
        return {e_cgnt, e_hgnt, e_en, e_we, e_addr, e_wdata, e_crv, e_hrv, e_crd, e_hrd};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 1, 0, 8'h01, '0, 1, 0, 8'h02, '0, 1);
        n_cmp++;
        if ({cpu_gnt, host_gnt, ram_en, cpu_rvalid, host_rvalid} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got gnt=%b%b en=%b rv=%b%b required all 0",
                     cpu_gnt, host_gnt, ram_en, cpu_rvalid, host_rvalid);
        end
        n_cmp++;
        if ({cpu_rdata, host_rdata} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata got %h/%h required 0/0", cpu_rdata, host_rdata);
        end
        tick();
        idle();
        n_cmp++;
        if ({ram_en, cpu_rvalid, host_rvalid} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset_release got en=%b rv=%b%b required 0", ram_en, cpu_rvalid, host_rvalid);
        end
        tick();
    endtask

    task automatic test_preload();
        for (int a = 0; a < 32; a++) begin
            drive(1, 0, 0, '0, '0, 1, 1, AW'(a), DW'($urandom), 0);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL preload a=%0d got %h required %h", a, got_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_cpu_write_read();
        drive(1, 1, 1, 8'h10, 16'hBEEF, 0, 0, '0, '0, 0);
        n_cmp++;
        if ({cpu_gnt, ram_en, ram_we, ram_addr, ram_wdata} !== {3'b111, 8'h10, 16'hBEEF}) begin
            n_bad++;
            $display("FAIL cpu_write got gnt=%b en=%b we=%b a=%h d=%h required 1 1 1 10 beef",
                     cpu_gnt, ram_en, ram_we, ram_addr, ram_wdata);
        end
        tick();
        drive(1, 1, 0, 8'h10, '0, 0, 0, '0, '0, 0);
        n_cmp++;
        if ({cpu_gnt, ram_en, ram_we, ram_addr} !== {3'b110, 8'h10}) begin
            n_bad++;
            $display("FAIL cpu_read_gnt got gnt=%b en=%b we=%b a=%h required 1 1 0 10",
                     cpu_gnt, ram_en, ram_we, ram_addr);
        end
        tick();
        idle();
        n_cmp++;
        if ({cpu_rvalid, cpu_rdata, host_rvalid, host_rdata} !== {1'b1, 16'hBEEF, 1'b0, 16'h0}) begin
            n_bad++;
            $display("FAIL cpu_read_data got rv=%b d=%h hrv=%b hd=%h required 1 beef 0 0",
                     cpu_rvalid, cpu_rdata, host_rvalid, host_rdata);
        end
        tick();
        idle();
        n_cmp++;
        if (cpu_rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_rvalid_len got %b required 0", cpu_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 8'h03, '0, 1, 0, 8'h04, '0, 0);
            n_cmp++;
            if ({cpu_gnt, host_gnt} !== {((i % 5) != 4), ((i % 5) == 4)}) begin
                n_bad++;
                $display("FAIL contention_gnt i=%0d got cpu=%b host=%b required cpu=%b host=%b",
                         i, cpu_gnt, host_gnt, ((i % 5) != 4), ((i % 5) == 4));
            end
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL contention_model i=%0d got %h required %h", i, got_vec(), exp_vec());
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_lock_burst();
        int hcnt = 0;
        for (int i = 0; i < 12; i++) begin
            logic hr;
            logic ec, eh;
            hr = (hcnt < 6);
            drive(1, 1, 0, 8'h14, '0, hr, 0, AW'(hcnt), '0, hr);
            ec = (i < 4) || (i == 11);
            eh = (i >= 4) && (i <= 9);
            n_cmp++;
            if ({cpu_gnt, host_gnt} !== {ec, eh}) begin
                n_bad++;
                $display("FAIL lock_gnt i=%0d got cpu=%b host=%b required cpu=%b host=%b",
                         i, cpu_gnt, host_gnt, ec, eh);
            end
            if (eh) begin
                n_cmp++;
                if (ram_addr !== AW'(i - 4)) begin
                    n_bad++;
                    $display("FAIL lock_addr i=%0d got %h required %h", i, ram_addr, AW'(i - 4));
                end
            end
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL lock_model i=%0d got %h required %h", i, got_vec(), exp_vec());
            end
            if (host_gnt) hcnt++;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_interleaved();
        logic [DW-1:0] w1, w2;
        w1 = DW'($urandom);
        w2 = ~w1;
        drive(1, 1, 1, 8'h01, w1, 0, 0, '0, '0, 0); tick();
        drive(1, 0, 0, '0, '0, 1, 1, 8'h02, w2, 0); tick();
        for (int i = 0; i < 9; i++) begin
            if (i == 8)          idle();
            else if (i % 2 == 0) drive(1, 1, 0, 8'h01, '0, 0, 0, '0, '0, 0);
            else                 drive(1, 0, 0, '0, '0, 1, 0, 8'h02, '0, 0);
            if (i > 0) begin
                logic [33:0] req;
                if (i % 2 == 1) req = {1'b1, w1, 1'b0, 16'h0};
                else            req = {1'b0, 16'h0, 1'b1, w2};
                n_cmp++;
                if ({cpu_rvalid, cpu_rdata, host_rvalid, host_rdata} !== req) begin
                    n_bad++;
                    $display("FAIL interleave i=%0d got crv=%b cd=%h hrv=%b hd=%h required %h",
                             i, cpu_rvalid, cpu_rdata, host_rvalid, host_rdata, req);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        // Two contended CPU reads push the starvation count to 2; the second
        // read's return is then killed by reset.
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 8'h05, '0, 1, 0, 8'h06, '0, 0);
            tick();
        end
        drive(0, 1, 0, 8'h05, '0, 1, 0, 8'h06, '0, 0);
        n_cmp++;
        if ({cpu_rvalid, host_rvalid, cpu_gnt, host_gnt, ram_en, cpu_rdata, host_rdata} !== 37'h0) begin
            n_bad++;
            $display("FAIL midrd_reset got rv=%b%b gnt=%b%b en=%b d=%h/%h required all 0",
                     cpu_rvalid, host_rvalid, cpu_gnt, host_gnt, ram_en, cpu_rdata, host_rdata);
        end
        tick();
        idle();
        n_cmp++;
        if ({cpu_rvalid, host_rvalid} !== 2'b00) begin
            n_bad++;
            $display("FAIL midrd_replay got rv=%b%b required 00", cpu_rvalid, host_rvalid);
        end
        tick();
        // Counter must start from zero again: host wins only on the 5th cycle.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 8'h05, '0, 1, 0, 8'h06, '0, 0);
            n_cmp++;
            if (host_gnt !== (i == 4)) begin
                n_bad++;
                $display("FAIL midrd_starve i=%0d got host_gnt=%b required %b", i, host_gnt, (i == 4));
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            idle();
            n_cmp++;
            if ({ram_en, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid} !== 5'b0) begin
                n_bad++;
                $display("FAIL idle i=%0d got en=%b gnt=%b%b rv=%b%b required 0",
                         i, ram_en, cpu_gnt, host_gnt, cpu_rvalid, host_rvalid);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic          c_act = 0, c_we = 0, h_act = 0, h_we = 0;
        logic [AW-1:0] c_a = '0, h_a = '0;
        logic [DW-1:0] c_d = '0, h_d = '0;
        for (int i = 0; i < 500; i++) begin
            logic cg, hg;
            if (!c_act && $urandom_range(0, 2) != 0) begin
                c_act = 1; c_we = $urandom_range(0, 1) == 1;
                c_a = AW'($urandom_range(0, 31)); c_d = DW'($urandom);
            end
            if (!h_act && $urandom_range(0, 2) != 0) begin
                h_act = 1; h_we = $urandom_range(0, 1) == 1;
                h_a = AW'($urandom_range(0, 31)); h_d = DW'($urandom);
            end
            drive(1, c_act, c_we, c_a, c_d, h_act, h_we, h_a, h_d, $urandom_range(0, 3) != 0);
            n_cmp++;
            if (got_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random i=%0d got %h required %h", i, got_vec(), exp_vec());
            end
            cg = cpu_gnt;
            hg = host_gnt;
            tick();
            if (cg) c_act = 0;
            if (hg) h_act = 0;
        end
        idle();
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random_tail got %h required %h", got_vec(), exp_vec());
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_preload();
        test_cpu_write_read();
        test_contention();
        test_lock_burst();
        test_interleaved();
        test_reset_mid_read();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
